// File: rtl/snake_pkg.sv
// Shared types and constants for the snake tile renderer.
// SNAKE_GRID_LINES_EN (see snake_pixel_gen) additionally uses COLOUR_GRID.
package snake_pkg;

  localparam logic [5:0]  GRID_W     = 6'd40;
  localparam logic [4:0]  GRID_H     = 5'd30;
  localparam int          TILE_SHIFT = 32'sd4;
  localparam logic [10:0] LAST_TILE  = 11'd1199;

  typedef logic [1:0] tile_t;

  localparam tile_t TILE_EMPTY = 2'd0;
  localparam tile_t TILE_BODY  = 2'd1;
  localparam tile_t TILE_HEAD  = 2'd2;
  localparam tile_t TILE_FOOD  = 2'd3;

  localparam logic [7:0] COLOUR_EMPTY = 8'h00;
  localparam logic [7:0] COLOUR_BODY  = 8'h1C;
  localparam logic [7:0] COLOUR_HEAD  = 8'hFC;
  localparam logic [7:0] COLOUR_FOOD  = 8'hE0;
  localparam logic [7:0] COLOUR_GRID  = 8'h49;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [7:0] tile_colour(input tile_t t);
    logic [7:0] c;
    case (t)
      TILE_EMPTY: c = COLOUR_EMPTY;
      TILE_BODY:  c = COLOUR_BODY;
      TILE_HEAD:  c = COLOUR_HEAD;
      TILE_FOOD:  c = COLOUR_FOOD;
      default:    c = COLOUR_EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_pixel_gen_tile_ram.sv
// Single-port 2048x2 tile store with registered read; contents are never reset.
module tile_ram
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [1:0]  wdata,
  output logic [1:0]  rdata
);

  tile_t mem [0:2047];
  tile_t rdata_q;

  // Write-first is irrelevant: reads and writes never target the same cycle's pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/snake_pixel_gen.sv
// Tile-map pixel renderer behind the VGA timing generator: 3-register pipeline to rgb.
// Optional: SNAKE_GRID_LINES_EN draws grey grid lines on empty tiles.
module snake_pixel_gen
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] r_pixel,
  input  logic [9:0] c_pixel,
  input  logic       video_on,
  input  logic       h_sync_i,
  input  logic       v_sync_i,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_tile,
  output logic       wr_ready,
  output logic       wr_err,
  input  logic       clr,
  output logic       busy,
  output logic       frame_start,
  output logic [7:0] rgb,
  output logic       h_sync_o,
  output logic       v_sync_o
);

  clr_state_e  state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        clr_issue_s;

  logic [10:0] addr_q, addr_d;
  logic        we_q, we_d;
  tile_t       wdata_q, wdata_d;
  logic        wr_err_q, wr_err_d;
  logic        frame_start_q, frame_start_d;
  logic        video1_q, video2_q;
  logic        hs1_q, hs2_q, hs_o_q;
  logic        vs1_q, vs2_q, vs_o_q;
  logic [7:0]  rgb_q, rgb_d;
  tile_t       rd_tile;
`ifdef SNAKE_GRID_LINES_EN
  logic        grid1_q, grid2_q;
`endif

  logic [10:0] pix_row_s, pix_addr_s, wr_row_s, wr_addr_s;
  logic        wr_in_range_s;

  // row*40 as (row<<5)+(row<<3) avoids a multiplier
  assign pix_row_s     = {5'd0, r_pixel[9:TILE_SHIFT]};
  assign pix_addr_s    = (pix_row_s << 5) + (pix_row_s << 3) + {5'd0, c_pixel[9:TILE_SHIFT]};
  assign wr_row_s      = {6'd0, wr_y};
  assign wr_addr_s     = (wr_row_s << 5) + (wr_row_s << 3) + {5'd0, wr_x};
  assign wr_in_range_s = (wr_x < GRID_W) && (wr_y < GRID_H);

  assign busy          = (state_q == ST_CLEAR);
  assign wr_ready      = ~video_on & ~busy & ~clr;
  assign frame_start_d = (r_pixel == 10'd480) && (c_pixel == 10'd0);

  // Clear sequencer: one tile per blanking cycle, clr restarts from tile 0.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_issue_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = 11'd0;
        end else begin
          clr_cnt_d = 11'd0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          clr_cnt_d = 11'd0;
        end else if (!video_on) begin
          clr_issue_s = 1'b1;
          if (clr_cnt_q == LAST_TILE) begin
            state_d   = ST_IDLE;
            clr_cnt_d = 11'd0;
          end else begin
            clr_cnt_d = clr_cnt_q + 11'd1;
          end
        end else begin
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = 11'd0;
      end
    endcase
  end

  // Stage 1 carries either the pixel read or a blanking-time write, so the
  // RAM write lands one cycle later, never displacing the last active read.
  always_comb begin
    addr_d   = pix_addr_s;
    we_d     = 1'b0;
    wdata_d  = TILE_EMPTY;
    wr_err_d = 1'b0;
    if (clr_issue_s) begin
      addr_d = clr_cnt_q;
      we_d   = 1'b1;
    end else if (wr_en && wr_ready) begin
      if (wr_in_range_s) begin
        addr_d  = wr_addr_s;
        we_d    = 1'b1;
        wdata_d = wr_tile;
      end else begin
        wr_err_d = 1'b1;
      end
    end else begin
      addr_d = pix_addr_s;
    end
  end

  // Colour lookup for the output register.
  always_comb begin
    rgb_d = COLOUR_EMPTY;
    if (video2_q) begin
`ifdef SNAKE_GRID_LINES_EN
      if ((rd_tile == TILE_EMPTY) && grid2_q) begin
        rgb_d = COLOUR_GRID;
      end else begin
        rgb_d = tile_colour(rd_tile);
      end
`else
      rgb_d = tile_colour(rd_tile);
`endif
    end else begin
      rgb_d = COLOUR_EMPTY;
    end
  end

  // Pipeline, FSM and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= 11'd0;
      addr_q        <= 11'd0;
      we_q          <= 1'b0;
      wdata_q       <= TILE_EMPTY;
      wr_err_q      <= 1'b0;
      frame_start_q <= 1'b0;
      video1_q      <= 1'b0;
      video2_q      <= 1'b0;
      hs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      hs_o_q        <= 1'b1;
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      vs_o_q        <= 1'b1;
      rgb_q         <= 8'h00;
`ifdef SNAKE_GRID_LINES_EN
      grid1_q       <= 1'b0;
      grid2_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      wr_err_q      <= wr_err_d;
      frame_start_q <= frame_start_d;
      video1_q      <= video_on;
      video2_q      <= video1_q;
      hs1_q         <= h_sync_i;
      hs2_q         <= hs1_q;
      hs_o_q        <= hs2_q;
      vs1_q         <= v_sync_i;
      vs2_q         <= vs1_q;
      vs_o_q        <= vs2_q;
      rgb_q         <= rgb_d;
`ifdef SNAKE_GRID_LINES_EN
      grid1_q       <= (r_pixel[TILE_SHIFT-1:0] == 4'd0) || (c_pixel[TILE_SHIFT-1:0] == 4'd0);
      grid2_q       <= grid1_q;
`endif
    end
  end

  tile_ram u_tile_ram (
    .clk   (clk),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rd_tile)
  );

  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;
  assign h_sync_o    = hs_o_q;
  assign v_sync_o    = vs_o_q;

endmodule
